// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad and hands debounced key codes to a consumer
// through a valid/ack handshake.
//
// One column at a time is driven low for SCAN_DIV clock cycles (a "slot").
// The row lines are synchronised and examined only on the last cycle of each
// slot. A key must be seen pressed on DEBOUNCE_SCANS consecutive slot ends
// before it is accepted. It must then be seen released on DEBOUNCE_SCANS
// consecutive slot ends before scanning resumes.
//
// Parameters:
//   SCAN_DIV        clk cycles per column slot (>= 4)
//   DEBOUNCE_SCANS  consecutive slot-end samples needed for press / release (>= 1)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   row[3:0]   in   keypad rows, active-low, asynchronous to clk
//   col[3:0]   out  column strobes, active-low, exactly one bit low
//   key[3:0]   out  key code, stable while key_valid is high
//   key_valid  out  a key code is pending for the consumer
//   key_ack    in   consumer accepts the pending key
//   key_held   out  the accepted key is still physically pressed
//   overrun    out  sticky: a key was accepted while another was still pending
//
// Build option:
//   KEYPAD_HEXMAP_EN  when defined, key codes follow the printed keypad legend
//                     (1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D). Otherwise the
//                     code is the raw position {row, column}.
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV       = 65536,
    parameter int DEBOUNCE_SCANS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       overrun
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        row_m;
    logic [3:0]        row_s;
    logic [DIV_W-1:0]  div;
    logic [1:0]        ci;
    logic [1:0]        ri;
    logic [CNT_W-1:0]  deb_cnt;
    logic [CNT_W-1:0]  rel_cnt;

    logic              slot_end;
    logic              any_low;
    logic              hit;
    logic              accept;
    logic [1:0]        acc_ri;
    logic [3:0]        acc_code;
    logic [CNT_W-1:0]  next_deb;
    logic [CNT_W-1:0]  next_rel;

    // Lowest-numbered row that is pulled low. Only called when at least one
    // row is low, so the final branch covers row 3.
    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        if (!r[0]) begin
            return 2'd0;
        end else if (!r[1]) begin
            return 2'd1;
        end else if (!r[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    // One-cold column strobe for column index c.
    function automatic logic [3:0] col_strobe(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    // Key code for the switch at row r, column c.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
`ifdef KEYPAD_HEXMAP_EN
        case ({r, c})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'h0;
            4'hD:    code = 4'hF;
            4'hE:    code = 4'hE;
            default: code = 4'hD;
        endcase
`else
        code = {r, c};
`endif
        return code;
    endfunction

    // Two-flop synchroniser for the asynchronous row inputs. Idle rows are
    // high, so both flops come out of reset as "no key".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_m <= 4'b1111;
            row_s <= 4'b1111;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    // Slot-end decode and the accept condition. A key can be accepted
    // straight from SCAN only when a single sample is enough to debounce.
    always_comb begin
        slot_end = (div == DIV_LAST);
        any_low  = ~&row_s;
        hit      = ~row_s[ri];
        next_deb = deb_cnt + 1'b1;
        next_rel = rel_cnt + 1'b1;
        accept   = 1'b0;
        acc_ri   = ri;
        if (state == SCAN) begin
            acc_ri = lowest_low(row_s);
        end
        if (slot_end) begin
            case (state)
                SCAN:     accept = any_low && (DEBOUNCE_SCANS == 1);
                DEBOUNCE: accept = hit && (next_deb == CNT_DONE);
                default:  accept = 1'b0;
            endcase
        end
        acc_code = key_code(acc_ri, ci);
    end

    // Scan state machine and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            div       <= '0;
            ci        <= 2'd0;
            ri        <= 2'd0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            col       <= 4'b1110;
            key       <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            div <= slot_end ? '0 : div + 1'b1;

            if (slot_end) begin
                case (state)
                    SCAN: begin
                        if (any_low) begin
                            // Column stays put while this row is watched.
                            ri <= lowest_low(row_s);
                            if (DEBOUNCE_SCANS == 1) begin
                                state   <= HELD;
                                deb_cnt <= '0;
                                rel_cnt <= '0;
                            end else begin
                                state   <= DEBOUNCE;
                                deb_cnt <= CNT_W'(1);
                            end
                        end else begin
                            ci  <= ci + 2'd1;
                            col <= col_strobe(ci + 2'd1);
                        end
                    end

                    DEBOUNCE: begin
                        // Only the captured row matters; other rows may
                        // change freely without disturbing the count.
                        if (hit) begin
                            if (next_deb == CNT_DONE) begin
                                state   <= HELD;
                                deb_cnt <= '0;
                                rel_cnt <= '0;
                            end else begin
                                deb_cnt <= next_deb;
                            end
                        end else begin
                            state   <= SCAN;
                            deb_cnt <= '0;
                            ci      <= ci + 2'd1;
                            col     <= col_strobe(ci + 2'd1);
                        end
                    end

                    HELD: begin
                        // Any low sample restarts the release count.
                        if (!hit) begin
                            if (next_rel == CNT_DONE) begin
                                state    <= SCAN;
                                rel_cnt  <= '0;
                                key_held <= 1'b0;
                                ci       <= ci + 2'd1;
                                col      <= col_strobe(ci + 2'd1);
                            end else begin
                                rel_cnt <= next_rel;
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end

                    default: begin
                        state <= SCAN;
                    end
                endcase
            end

            // Handshake. An ack in the accept cycle frees the slot for the
            // new key; otherwise a still-pending key is kept and the loss is
            // flagged.
            if (accept) begin
                key_held <= 1'b1;
                if (key_valid && !key_ack) begin
                    overrun <= 1'b1;
                end else begin
                    key       <= acc_code;
                    key_valid <= 1'b1;
                end
            end else if (key_valid && key_ack) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Directed bench for keypad_scanner (SCAN_DIV = 4, DEBOUNCE_SCANS = 3).
// A simulated key matrix drives the row pins from the DUT's column strobes.
// A behavioural model, stepped once per cycle, predicts every output and is
// compared on each falling clock edge. Hand-computed literal expectations in
// the stimulus process pin the model down.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_ack   = 1'b0;
    logic        key_held;
    logic        overrun;
    logic [15:0] press_map = 16'h0000;   // bit r*4+c: switch (r,c) closed

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    // Matrix physics: a closed switch pulls its row low while its column is low.
    function automatic logic [3:0] pins_for(input logic [3:0] c, input logic [15:0] pm);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (pm[i*4+j] && !c[j]) r[i] = 1'b0;
        return r;
    endfunction

    assign row = pins_for(col, press_map);

    function automatic logic [3:0] exp_code(input int r, input int c);
`ifdef KEYPAD_HEXMAP_EN
        logic [3:0] legend [16];
        legend = '{4'h1, 4'h2, 4'h3, 4'hA,
                   4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC,
                   4'h0, 4'hF, 4'hE, 4'hD};
        return legend[r*4+c];
`else
        return 4'(r*4 + c);
`endif
    endfunction

    // ---------------- behavioural model ----------------
    // mode: 0 = looking for a key, 1 = counting press samples, 2 = key down
    int         m_div, m_ci, m_ri, m_mode, m_streak, m_rel;
    logic [3:0] m_key;
    logic       m_valid, m_held, m_ovr;
    logic [3:0] m_h0, m_h1;             // pins one and two edges back

    task automatic model_reset();
        m_div = 0; m_ci = 0; m_ri = 0; m_mode = 0; m_streak = 0; m_rel = 0;
        m_key = 4'h0; m_valid = 1'b0; m_held = 1'b0; m_ovr = 1'b0;
        m_h0 = 4'hF; m_h1 = 4'hF;
    endtask

    function automatic logic [3:0] model_col();
        return ~(4'b0001 << m_ci);
    endfunction

    // Advances the model across one rising edge given the inputs seen there.
    task automatic model_step(input logic [3:0] pins, input logic ack);
        logic [3:0] rs;
        bit         at_end;
        bit         acc;
        rs     = m_h1;
        m_h1   = m_h0;
        m_h0   = pins;
        at_end = (m_div == SCAN_DIV - 1);
        m_div  = (m_div + 1) % SCAN_DIV;
        acc    = 1'b0;
        if (at_end) begin
            if (m_mode == 0) begin
                if (rs != 4'hF) begin
                    m_ri = 0;
                    while (rs[m_ri]) m_ri++;
                    m_streak = 1;
                    m_mode   = (DEB == 1) ? 2 : 1;
                    acc      = (DEB == 1);
                    m_rel    = 0;
                end else begin
                    m_ci = (m_ci + 1) % 4;
                end
            end else if (m_mode == 1) begin
                if (!rs[m_ri]) begin
                    m_streak++;
                    if (m_streak == DEB) begin
                        m_mode = 2; acc = 1'b1; m_rel = 0;
                    end
                end else begin
                    m_mode = 0; m_streak = 0; m_ci = (m_ci + 1) % 4;
                end
            end else begin
                m_rel = rs[m_ri] ? m_rel + 1 : 0;
                if (m_rel == DEB) begin
                    m_held = 1'b0; m_rel = 0; m_mode = 0; m_ci = (m_ci + 1) % 4;
                end
            end
        end
        if (acc) begin
            m_held = 1'b1;
            if (m_valid && !ack) m_ovr = 1'b1;
            else begin
                m_key   = exp_code(m_ri, m_ci);
                m_valid = 1'b1;
            end
        end else if (m_valid && ack) begin
            m_valid = 1'b0;
        end
    endtask

    // True when the coming rising edge will accept a key.
    function automatic bit accept_next();
        if (m_div != SCAN_DIV - 1) return 1'b0;
        if (m_mode == 1) return (m_streak == DEB - 1) && !m_h1[m_ri];
        if (m_mode == 0 && DEB == 1) return m_h1 != 4'hF;
        return 1'b0;
    endfunction

    initial model_reset();

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        checks++;
        if ({col, key, key_valid, key_held, overrun} !==
            {model_col(), m_key, m_valid, m_held, m_ovr}) begin
            failures++;
            $display("FAIL cycle_compare t=%0t got col=%b key=%h v=%b h=%b o=%b want col=%b key=%h v=%b h=%b o=%b",
                     $time, col, key, key_valid, key_held, overrun,
                     model_col(), m_key, m_valid, m_held, m_ovr);
        end
        if (rst_n) model_step(pins_for(model_col(), press_map), key_ack);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    // sel 0: key_valid == val[0], sel 1: key_held == val[0], else col == val
    task automatic wait_sig(input string name, input int sel, input logic [3:0] val, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            case (sel)
                0:       hit = (key_valid === val[0]);
                1:       hit = (key_held === val[0]);
                default: hit = (col === val);
            endcase
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL %s timeout after %0d cycles want=%b", name, budget, val);
        end
    endtask

    task automatic press(input int r, input int c);
        press_map[r*4+c] = 1'b1;
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        bit ok;

        // Reset values
        repeat (3) tick();
        chk("reset_col", col, 4'b1110);
        chk("reset_key", key, 4'h0);
        chk("reset_valid", key_valid, 1'b0);
        chk("reset_held", key_held, 1'b0);
        chk("reset_overrun", overrun, 1'b0);
        rst_n = 1'b1;

        // Clean press of row 1 / column 2, then release
        press(1, 2);
        wait_sig("press_valid", 0, 4'h1, 100);
        chk("press_key", key, 4'h6);
        chk("press_key_map", key, exp_code(1, 2));
        chk("press_held", key_held, 1'b1);
        chk("press_col_frozen", col, 4'b1011);
        press_map = 16'h0000;
        wait_sig("release_held", 1, 4'h0, 100);
        chk("resume_col", col, 4'b0111);
        chk("still_pending", key_valid, 1'b1);

        // Handshake: no ack for 20 cycles, then a single-cycle ack
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("wait_valid", key_valid, 1'b1);
            chk("wait_key", key, 4'h6);
        end
        ack_pulse();
        chk("ack_drops_valid", key_valid, 1'b0);

        // Bounce: two matching slots only under column 0
        wait_sig("bounce_align1", 2, 4'b1101, 40);
        wait_sig("bounce_align0", 2, 4'b1110, 40);
        press(0, 0);
        repeat (8) tick();
        press_map = 16'h0000;
        chk("bounce_col_frozen", col, 4'b1110);
        wait_sig("bounce_advance", 2, 4'b1101, 20);
        chk("bounce_valid", key_valid, 1'b0);
        chk("bounce_held", key_held, 1'b0);

        // Overrun: second key while the first is still pending
        press(0, 0);
        wait_sig("ovr_first_valid", 0, 4'h1, 100);
        chk("ovr_first_key", key, exp_code(0, 0));
        press_map = 16'h0000;
        wait_sig("ovr_first_release", 1, 4'h0, 100);
        press(3, 3);
        wait_sig("ovr_second_held", 1, 4'h1, 100);
        chk("ovr_key_kept", key, exp_code(0, 0));
        chk("ovr_valid", key_valid, 1'b1);
        chk("ovr_flag", overrun, 1'b1);
        press_map = 16'h0000;
        ack_pulse();
        chk("ovr_ack_valid", key_valid, 1'b0);
        chk("ovr_sticky", overrun, 1'b1);
        wait_sig("ovr_second_release", 1, 4'h0, 100);

        // Reset while debouncing column 1, then column rotation from reset
        wait_sig("rst_align0", 2, 4'b1110, 40);
        wait_sig("rst_align1", 2, 4'b1101, 40);
        press(0, 1);
        repeat (6) tick();
        chk("deb_col_frozen", col, 4'b1101);
        rst_n = 1'b0;
        #1;
        chk("async_rst_col", col, 4'b1110);
        chk("async_rst_valid", key_valid, 1'b0);
        chk("async_rst_held", key_held, 1'b0);
        chk("async_rst_overrun", overrun, 1'b0);
        press_map = 16'h0000;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            logic [3:0] want_col;
            if (k > 0) tick();
            want_col = ~(4'b0001 << (k / 4));
            chk("rotate_col", col, want_col);
        end

        // Accept coinciding with an ack: new key loads, no overrun
        press(0, 0);
        wait_sig("same_first_valid", 0, 4'h1, 100);
        press_map = 16'h0000;
        wait_sig("same_first_release", 1, 4'h0, 100);
        press(3, 3);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (accept_next()) begin
                ack_pulse();
                ok = 1'b1;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL same_accept_timeout got=0 want=1");
        end
        chk("same_key", key, exp_code(3, 3));
        chk("same_valid", key_valid, 1'b1);
        chk("same_overrun", overrun, 1'b0);
        chk("same_held", key_held, 1'b1);
        press_map = 16'h0000;
        wait_sig("same_release", 1, 4'h0, 100);
        ack_pulse();
        chk("same_ack_valid", key_valid, 1'b0);

        // Two rows low under column 1: lowest row wins
        press(0, 1);
        press(2, 1);
        wait_sig("multi_valid", 0, 4'h1, 100);
        chk("multi_key", key, exp_code(0, 1));
`ifndef KEYPAD_HEXMAP_EN
        chk("multi_key_raw", key, 4'h1);
`endif
        chk("multi_col", col, 4'b1101);
        press_map = 16'h0000;
        wait_sig("multi_release", 1, 4'h0, 100);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
